// File: rtl/pipelined_add_sub_pkg.sv
// Shared types and helpers for the carry-chunked pipelined adder/subtractor.
package pipelined_add_sub_pkg;

  localparam int unsigned FLAG_W = 4;

  typedef struct packed {
    logic ovf;
    logic neg;
    logic zero;
    logic carry;
  } alu_flags_t;

  // Width of one carry chunk; WIDTH is required to be a multiple of STAGES.
  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_add_sub_add_chunk_stage.sv
// One CHUNK-bit slice of the carry chain: registered add with carry in/out, holds on stall.
module add_chunk_stage
  import pipelined_add_sub_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_c,
  output logic [CHUNK-1:0] o_s,
  output logic             o_c
);

  localparam int unsigned SUM_W = CHUNK + 1;

  logic [SUM_W-1:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + SUM_W'(i_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_s <= '0;
      o_c <= 1'b0;
    end else if (i_en) begin
      o_s <= w_sum[CHUNK-1:0];
      o_c <= w_sum[CHUNK];
    end
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// STAGES-deep carry-chunked adder/subtractor with valid/ready flow control.
// Define PIPE_ADD_FLAGS_EN to add the {ovf,neg,zero,carry} flags output.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              sub,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  sum,
  output logic              cout
`ifdef PIPE_ADD_FLAGS_EN
  ,
  output logic [FLAG_W-1:0] flags
`endif
);

  localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

  logic              w_advance;
  logic [WIDTH-1:0]  w_b_eff;
  logic [WIDTH-1:0]  w_sum;
  logic [STAGES-1:0] r_v;
  // Per-stage operand copies (pending high chunks) and completed low result chunks.
  logic [WIDTH-1:0]  r_a  [STAGES];
  logic [WIDTH-1:0]  r_b  [STAGES];
  logic [WIDTH-1:0]  r_lo [STAGES];
  logic [CHUNK-1:0]  w_s  [STAGES];
  logic              w_c  [STAGES];

  assign w_advance = !r_v[STAGES-1] || out_ready;
  assign in_ready  = w_advance;
  assign w_b_eff   = sub ? ~b : b;

  // Valid chain and forwarding registers; the whole pipe freezes when the tail is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_a[k]  <= '0;
        r_b[k]  <= '0;
        r_lo[k] <= '0;
      end
    end else if (w_advance) begin
      r_v[0] <= in_valid;
      r_a[0] <= a;
      r_b[0] <= w_b_eff;
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_v[k]  <= r_v[k-1];
        r_a[k]  <= r_a[k-1];
        r_b[k]  <= r_b[k-1];
        r_lo[k] <= r_lo[k-1];
        r_lo[k][(k-1)*CHUNK +: CHUNK] <= w_s[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_ci;

    if (k == 0) begin : g_first
      assign w_ca = a[CHUNK-1:0];
      assign w_cb = w_b_eff[CHUNK-1:0];
      assign w_ci = cin;
    end else begin : g_rest
      assign w_ca = r_a[k-1][k*CHUNK +: CHUNK];
      assign w_cb = r_b[k-1][k*CHUNK +: CHUNK];
      assign w_ci = w_c[k-1];
    end

    add_chunk_stage #(
      .CHUNK (CHUNK)
    ) u_add (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_advance),
      .i_a   (w_ca),
      .i_b   (w_cb),
      .i_c   (w_ci),
      .o_s   (w_s[k]),
      .o_c   (w_c[k])
    );
  end

  // Final result: forwarded low chunks with the top chunk from the last slice.
  always_comb begin
    w_sum = r_lo[STAGES-1];
    w_sum[(STAGES-1)*CHUNK +: CHUNK] = w_s[STAGES-1];
  end

  assign sum       = w_sum;
  assign cout      = w_c[STAGES-1];
  assign out_valid = r_v[STAGES-1];

`ifdef PIPE_ADD_FLAGS_EN
  alu_flags_t w_flags;

  // Flags read as zero while no result is presented, so reset leaves them clear.
  always_comb begin
    w_flags = '0;
    if (r_v[STAGES-1]) begin
      w_flags.carry = w_c[STAGES-1];
      w_flags.zero  = (w_sum == '0);
      w_flags.neg   = w_sum[WIDTH-1];
      w_flags.ovf   = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1]) &&
                      (w_sum[WIDTH-1] != r_a[STAGES-1][WIDTH-1]);
    end
  end

  assign flags = w_flags;
`endif

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (WIDTH=32, STAGES=4) against an arithmetic model.
module tb_pipelined_add_sub;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_ADD_FLAGS_EN
  logic [3:0]       flags;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH:0] q_res [$];
  logic [3:0]     q_flg [$];

  pipelined_add_sub #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADD_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: full (WIDTH+1)-bit result of a + (sub ? ~b : b) + cin.
  function automatic logic [WIDTH:0] model_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic s, input logic c);
    logic [WIDTH-1:0] yy;
    yy = s ? ~y : y;
    return {1'b0, x} + {1'b0, yy} + (WIDTH+1)'(c);
  endfunction

  // Reference flags {ovf,neg,zero,carry}; ovf from signed range of the exact sum.
  function automatic logic [3:0] model_flg(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s, input logic c);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] yy;
    longint           xv;
    longint           yv;
    longint           r;
    logic             ovf;
    full = model_res(x, y, s, c);
    yy   = s ? ~y : y;
    xv   = $signed(x);
    yv   = $signed(yy);
    r    = xv + yv + longint'(c);
    ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {ovf, full[WIDTH-1], (full[WIDTH-1:0] == '0), full[WIDTH]};
  endfunction

  task automatic push_model();
    q_res.push_back(model_res(a, b, sub, cin));
    q_flg.push_back(model_flg(a, b, sub, cin));
  endtask

  function automatic logic [3:0] obs_flags();
`ifdef PIPE_ADD_FLAGS_EN
    return flags;
`else
    return 4'h0;
`endif
  endfunction

  // Drives one beat into an idle pipe and reports the result and cycles to presentation.
  task automatic issue_one(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                           input logic c, output logic [WIDTH:0] res, output logic [3:0] flg,
                           output int lat);
    int e;
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; sub = s; cin = c; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    e   = 1;
    while (lat == 0 && e <= 20) begin
      @(negedge clk);
      if (out_valid === 1'b1) lat = e;
      else begin
        @(posedge clk);
        e++;
      end
    end
    res = {cout, sum};
    flg = obs_flags();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #23;
    n_vec++;
    if ({out_valid, cout, sum} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b cout=%b sum=%h, expected 0/0/0", out_valid, cout, sum);
    end
    n_vec++;
    if (obs_flags() !== 4'h0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 0000", obs_flags());
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, cout, sum} !== '0) begin
      n_err++;
      $display("FAIL reset_midflight: got valid=%b cout=%b sum=%h, expected 0/0/0", out_valid, cout, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL reset_discard: got %0d emerging beats, expected 0", seen);
    end
  endtask

  task automatic test_latency();
    logic [WIDTH:0] res;
    logic [3:0]     flg;
    int             lat;
    issue_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, res, flg, lat);
    n_vec++;
    if (lat != STAGES) begin
      n_err++;
      $display("FAIL latency: got %0d cycles expected %0d", lat, STAGES);
    end
    n_vec++;
    if (res !== 33'h1_0000_0000) begin
      n_err++;
      $display("FAIL wrap_add: got {cout,sum}=%h expected 100000000", res);
    end
  endtask

  task automatic test_sub();
    logic [WIDTH-1:0] xs [2];
    logic [WIDTH-1:0] ys [2];
    logic [WIDTH:0]   er [2];
    logic [3:0]       ef [2];
    logic [WIDTH:0]   res;
    logic [3:0]       flg;
    int               lat;
    xs[0] = 32'd5; ys[0] = 32'd7; er[0] = {1'b0, 32'hFFFF_FFFE}; ef[0] = 4'b0100;
    xs[1] = 32'd7; ys[1] = 32'd5; er[1] = {1'b1, 32'h0000_0002}; ef[1] = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      issue_one(xs[i], ys[i], 1'b1, 1'b1, res, flg, lat);
      n_vec++;
      if (lat == 0 || res !== er[i]) begin
        n_err++;
        $display("FAIL sub_%0d: got {cout,sum}=%h (lat %0d) expected %h", i, res, lat, er[i]);
      end
`ifdef PIPE_ADD_FLAGS_EN
      n_vec++;
      if (flg !== ef[i]) begin
        n_err++;
        $display("FAIL sub_flags_%0d: got %b expected %b", i, flg, ef[i]);
      end
`endif
    end
    n_vec++;
    issue_one(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, res, flg, lat);
    if (lat == 0 || res !== 33'h1_0000_0000) begin
      n_err++;
      $display("FAIL sub_equal: got {cout,sum}=%h expected 100000000", res);
    end
  endtask

  task automatic test_flags();
    logic [WIDTH:0] res;
    logic [3:0]     flg;
    int             lat;
    issue_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, res, flg, lat);
    n_vec++;
    if (lat == 0 || res !== {1'b0, 32'h8000_0000}) begin
      n_err++;
      $display("FAIL ovf_sum: got {cout,sum}=%h expected 080000000", res);
    end
`ifdef PIPE_ADD_FLAGS_EN
    n_vec++;
    if (flg !== 4'b1100) begin
      n_err++;
      $display("FAIL ovf_flags: got %b expected 1100", flg);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int             sent = 0;
    int             got  = 0;
    int             cyc  = 0;
    int             extra = 0;
    bit             hold = 0;
    logic [WIDTH:0] exp_r;
    logic [3:0]     exp_f;
    while ((sent < 100 || q_res.size() > 0) && cyc < 3000) begin
      @(posedge clk); #1;
      if (!hold) begin
        if (sent < 100) begin
          in_valid = ($urandom_range(0, 3) != 0);
          a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        end else in_valid = 1'b0;
      end
      out_ready = 1'($urandom);
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        if (q_res.size() == 0) begin
          n_err++;
          $display("FAIL b2b_dup: got unexpected result %h, expected none", {cout, sum});
        end else begin
          exp_r = q_res.pop_front();
          exp_f = q_flg.pop_front();
          got++;
          if ({cout, sum} !== exp_r) begin
            n_err++;
            $display("FAIL b2b_result: got %h expected %h", {cout, sum}, exp_r);
          end
`ifdef PIPE_ADD_FLAGS_EN
          else if (flags !== exp_f) begin
            n_err++;
            $display("FAIL b2b_flags: got %b expected %b", flags, exp_f);
          end
`endif
        end
      end
      hold = in_valid && !in_ready;
      if (in_valid && in_ready) begin
        push_model();
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) extra++;
    end
    n_vec++;
    if (sent != 100 || got != 100 || extra != 0) begin
      n_err++;
      $display("FAIL b2b_count: got sent=%0d recv=%0d extra=%0d expected 100/100/0", sent, got, extra);
    end
    q_res.delete();
    q_flg.delete();
  endtask

  task automatic test_stall();
    int             acc = 0;
    int             cyc = 0;
    logic [WIDTH:0] snap;
    logic [WIDTH:0] exp_r;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    while (cyc < 20) begin
      @(negedge clk);
      if (!in_ready) break;
      push_model();
      acc++;
      @(posedge clk); #1;
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      cyc++;
    end
    n_vec++;
    if (acc != STAGES) begin
      n_err++;
      $display("FAIL stall_fill: got %0d accepted expected %0d", acc, STAGES);
    end
    snap = {cout, sum};
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {cout, sum} !== snap) begin
        n_err++;
        $display("FAIL stall_hold: got ready=%b valid=%b res=%h expected 0/1/%h",
                 in_ready, out_valid, {cout, sum}, snap);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i <= STAGES; i++) begin
      @(negedge clk);
      n_vec++;
      if (i < STAGES) begin
        exp_r = (q_res.size() > 0) ? q_res.pop_front() : 'x;
        if (out_valid !== 1'b1 || {cout, sum} !== exp_r) begin
          n_err++;
          $display("FAIL stall_drain_%0d: got valid=%b res=%h expected 1/%h", i, out_valid, {cout, sum}, exp_r);
        end
      end else if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stall_empty: got valid=%b expected 0", out_valid);
      end
      @(posedge clk);
    end
    q_res.delete();
    q_flg.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sub();
    test_flags();
    test_back_to_back();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
